// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared state encoding and sign helpers for the iterative divider
package div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } div_state_t;

    // Two's-complement magnitude of a value whose sign has already been decided.
    function automatic logic [31:0] magnitude(input logic [31:0] value, input logic is_neg);
        return is_neg ? (~value + 32'd1) : value;
    endfunction

    function automatic logic [31:0] apply_sign(input logic [31:0] value, input logic make_neg);
        return make_neg ? (32'd0 - value) : value;
    endfunction

endpackage

// File: rtl/div_sign_fix.sv
// rtl/div_sign_fix.sv - turns unsigned quotient/remainder magnitudes into the final signed results
module div_sign_fix
    import div_pkg::*;
#(
    parameter int A_WIDTH  = 10,
    parameter int B_WIDTH  = 10,
    parameter int TC_MODE  = 0,
    parameter int REM_MODE = 1
) (
    input  logic [A_WIDTH-1:0] q_mag,
    input  logic [B_WIDTH-1:0] r_mag,
    input  logic [B_WIDTH-1:0] b_val,
    input  logic               a_neg,
    input  logic               b_neg,
    input  logic               b_zero,
    output logic [A_WIDTH-1:0] quotient,
    output logic [B_WIDTH-1:0] remainder
);

    localparam logic [A_WIDTH-1:0] Q_MAX_POS = {1'b0, {(A_WIDTH-1){1'b1}}};
    localparam logic [A_WIDTH-1:0] Q_MAX_NEG = {1'b1, {(A_WIDTH-1){1'b0}}};

    always_comb begin
        quotient  = A_WIDTH'(apply_sign(32'(q_mag), a_neg ^ b_neg));
        remainder = B_WIDTH'(apply_sign(32'(r_mag), a_neg));
        // Modulus takes the divisor's sign: shift a nonzero remainder by one divisor.
        if (REM_MODE == 0 && r_mag != '0 && a_neg != b_neg) begin
            remainder = remainder + b_val;
        end
        if (b_zero) begin
            remainder = '0;
            if (TC_MODE != 0) begin
                quotient = a_neg ? Q_MAX_NEG : Q_MAX_POS;
            end else begin
                quotient = '1;
            end
        end
    end

endmodule

// File: rtl/iter_divider.sv
// rtl/iter_divider.sv - restoring divider, one quotient bit per cycle, valid/ready handshakes
module iter_divider
    import div_pkg::*;
#(
    parameter int A_WIDTH  = 10,
    parameter int B_WIDTH  = 10,
    parameter int TC_MODE  = 0,
    parameter int REM_MODE = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [A_WIDTH-1:0] a,
    input  logic [B_WIDTH-1:0] b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [A_WIDTH-1:0] quotient,
    output logic [B_WIDTH-1:0] remainder,
    output logic               divide_by_0
);

    localparam int CNT_W = $clog2(A_WIDTH + 1);

    div_state_t         state, state_n;
    logic [CNT_W-1:0]   cnt;
    logic [A_WIDTH-1:0] q_sh;
    logic [B_WIDTH-1:0] rem_sh;
    logic [B_WIDTH-1:0] b_mag;
    logic [B_WIDTH-1:0] b_val;
    logic               a_neg, b_neg, b_zero;
    logic               in_a_neg, in_b_neg;
    logic [B_WIDTH:0]   trial;
    logic               ge;
    logic [A_WIDTH-1:0] q_fix;
    logic [B_WIDTH-1:0] r_fix;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign in_a_neg  = (TC_MODE != 0) && a[A_WIDTH-1];
    assign in_b_neg  = (TC_MODE != 0) && b[B_WIDTH-1];

    // q_sh doubles as dividend shifter and quotient accumulator.
    assign trial = {rem_sh, q_sh[A_WIDTH-1]};
    assign ge    = (trial >= {1'b0, b_mag});

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (in_valid) state_n = (b == '0) ? FIX : CALC;
            CALC:    if (cnt == CNT_W'(A_WIDTH - 1)) state_n = FIX;
            FIX:     state_n = DONE;
            DONE:    if (out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            q_sh        <= '0;
            rem_sh      <= '0;
            b_mag       <= '0;
            b_val       <= '0;
            a_neg       <= 1'b0;
            b_neg       <= 1'b0;
            b_zero      <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            divide_by_0 <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        q_sh   <= A_WIDTH'(magnitude(32'(a), in_a_neg));
                        rem_sh <= '0;
                        b_mag  <= B_WIDTH'(magnitude(32'(b), in_b_neg));
                        b_val  <= b;
                        a_neg  <= in_a_neg;
                        b_neg  <= in_b_neg;
                        b_zero <= (b == '0);
                        cnt    <= '0;
                    end
                end
                CALC: begin
                    q_sh   <= {q_sh[A_WIDTH-2:0], ge};
                    rem_sh <= ge ? (trial[B_WIDTH-1:0] - b_mag) : trial[B_WIDTH-1:0];
                    cnt    <= cnt + CNT_W'(1);
                end
                FIX: begin
                    quotient    <= q_fix;
                    remainder   <= r_fix;
                    divide_by_0 <= b_zero;
                end
                default: ;
            endcase
        end
    end

    div_sign_fix #(
        .A_WIDTH (A_WIDTH),
        .B_WIDTH (B_WIDTH),
        .TC_MODE (TC_MODE),
        .REM_MODE(REM_MODE)
    ) u_sign_fix (
        .q_mag    (q_sh),
        .r_mag    (rem_sh),
        .b_val    (b_val),
        .a_neg    (a_neg),
        .b_neg    (b_neg),
        .b_zero   (b_zero),
        .quotient (q_fix),
        .remainder(r_fix)
    );

endmodule

// File: tb/tb_iter_divider.sv
// tb/tb_iter_divider.sv - directed vectors for unsigned, signed-remainder and signed-modulus dividers
module tb_iter_divider;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       out_ready;
    logic [9:0] a, b;

    logic       ir_u, ov_u, d_u, ir_s, ov_s, d_s, ir_m, ov_m, d_m;
    logic [9:0] q_u, r_u, q_s, r_s, q_m, r_m;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [9:0] a;
        logic [9:0] b;
        logic [9:0] q_u;
        logic [9:0] r_u;
        logic [9:0] q_s;
        logic [9:0] r_s;
        logic [9:0] r_m;
        logic       d0;
    } vec_t;

    vec_t vecs[12];

    always #5 clk = ~clk;

    iter_divider #(.TC_MODE(0), .REM_MODE(1)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_u), .a(a), .b(b),
        .out_valid(ov_u), .out_ready(out_ready), .quotient(q_u), .remainder(r_u), .divide_by_0(d_u)
    );

    iter_divider #(.TC_MODE(1), .REM_MODE(1)) u_tc (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_s), .a(a), .b(b),
        .out_valid(ov_s), .out_ready(out_ready), .quotient(q_s), .remainder(r_s), .divide_by_0(d_s)
    );

    iter_divider #(.TC_MODE(1), .REM_MODE(0)) u_mod (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_m), .a(a), .b(b),
        .out_valid(ov_m), .out_ready(out_ready), .quotient(q_m), .remainder(r_m), .divide_by_0(d_m)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_result(input string tag, input vec_t v);
        chk({tag, "_ov_s"}, int'(ov_s), 1);
        chk({tag, "_ov_m"}, int'(ov_m), 1);
        chk({tag, "_q_u"}, int'(q_u), int'(v.q_u));
        chk({tag, "_r_u"}, int'(r_u), int'(v.r_u));
        chk({tag, "_d_u"}, int'(d_u), int'(v.d0));
        chk({tag, "_q_s"}, int'(q_s), int'(v.q_s));
        chk({tag, "_r_s"}, int'(r_s), int'(v.r_s));
        chk({tag, "_d_s"}, int'(d_s), int'(v.d0));
        chk({tag, "_q_m"}, int'(q_m), int'(v.q_s));
        chk({tag, "_r_m"}, int'(r_m), int'(v.r_m));
        chk({tag, "_d_m"}, int'(d_m), int'(v.d0));
    endtask

    // Entered #1 after a rising edge with all three dividers idle.
    task automatic run_op(input string tag, input vec_t v);
        int lat;
        chk({tag, "_in_ready_pre"}, int'(ir_u), 1);
        in_valid = 1'b1;
        a = v.a;
        b = v.b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (ov_u) begin
                lat = c;
                break;
            end
        end
        chk({tag, "_latency"}, lat, (v.b == 10'd0) ? 1 : 11);
        chk_result(tag, v);
        @(posedge clk); #1;
        chk({tag, "_in_ready_post"}, int'(ir_u & ir_s & ir_m), 1);
        chk({tag, "_out_valid_post"}, int'(ov_u | ov_s | ov_m), 0);
    endtask

    initial begin
        vec_t hold_v;
        vec_t v93;
        int   lat;
        int   seen;

        //               a        b        q_u      r_u      q_s      r_s      r_m      d0
        vecs[0]  = '{10'd1000, 10'd7,    10'd142,  10'd6,   10'd1021, 10'd1021, 10'd4,    1'b0};
        vecs[1]  = '{10'd513,  10'd0,    10'd1023, 10'd0,   10'd512,  10'd0,    10'd0,    1'b1};
        vecs[2]  = '{10'd924,  10'd7,    10'd132,  10'd0,   10'd1010, 10'd1022, 10'd5,    1'b0};
        vecs[3]  = '{10'd512,  10'd1023, 10'd0,    10'd512, 10'd512,  10'd0,    10'd0,    1'b0};
        vecs[4]  = '{10'd9,    10'd3,    10'd3,    10'd0,   10'd3,    10'd0,    10'd0,    1'b0};
        vecs[5]  = '{10'd100,  10'd1017, 10'd0,    10'd100, 10'd1010, 10'd2,    10'd1019, 1'b0};
        vecs[6]  = '{10'd924,  10'd1017, 10'd0,    10'd924, 10'd14,   10'd1022, 10'd1022, 1'b0};
        vecs[7]  = '{10'd0,    10'd5,    10'd0,    10'd0,   10'd0,    10'd0,    10'd0,    1'b0};
        vecs[8]  = '{10'd1023, 10'd1,    10'd1023, 10'd0,   10'd1023, 10'd0,    10'd0,    1'b0};
        vecs[9]  = '{10'd5,    10'd1023, 10'd0,    10'd5,   10'd1019, 10'd0,    10'd0,    1'b0};
        vecs[10] = '{10'd511,  10'd512,  10'd0,    10'd511, 10'd0,    10'd511,  10'd1023, 1'b0};
        vecs[11] = '{10'd0,    10'd0,    10'd1023, 10'd0,   10'd511,  10'd0,    10'd0,    1'b1};
        hold_v   = '{10'd7,    10'd2,    10'd3,    10'd1,   10'd3,    10'd1,    10'd1,    1'b0};
        v93      = vecs[4];

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        a = '0;
        b = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_in_ready", int'(ir_u & ir_s & ir_m), 1);
        chk("rst_out_valid", int'(ov_u | ov_s | ov_m), 0);
        chk("rst_quotient", int'(q_u), 0);
        chk("rst_remainder", int'(r_u), 0);
        chk("rst_div0", int'(d_u), 0);

        for (int i = 0; i < 12; i++) begin
            run_op($sformatf("v%0d", i), vecs[i]);
        end

        // Result held under back-pressure while a different operand pair waits on the inputs.
        out_ready = 1'b0;
        in_valid = 1'b1;
        a = 10'd5;
        b = 10'd1023;
        @(posedge clk); #1;
        a = 10'd7;
        b = 10'd2;
        lat = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (ov_u) begin
                lat = c;
                break;
            end
        end
        chk("hold_latency", lat, 11);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk($sformatf("hold%0d_out_valid", k), int'(ov_u), 1);
            chk($sformatf("hold%0d_in_ready", k), int'(ir_u), 0);
            chk($sformatf("hold%0d_q_u", k), int'(q_u), 0);
            chk($sformatf("hold%0d_r_u", k), int'(r_u), 5);
            chk($sformatf("hold%0d_q_s", k), int'(q_s), 1019);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("release_in_ready", int'(ir_u), 1);
        chk("release_out_valid", int'(ov_u), 0);
        lat = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (c == 1) in_valid = 1'b0;
            if (ov_u) begin
                lat = c;
                break;
            end
        end
        chk("reissue_latency", lat, 12);
        chk_result("reissue", hold_v);
        @(posedge clk); #1;
        chk("reissue_idle", int'(ir_u), 1);

        // Reset in the middle of CALC discards the operation and clears held results.
        in_valid = 1'b1;
        a = 10'd1000;
        b = 10'd7;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_in_ready", int'(ir_u & ir_s & ir_m), 1);
        chk("midrst_out_valid", int'(ov_u | ov_s | ov_m), 0);
        chk("midrst_q_u", int'(q_u), 0);
        chk("midrst_r_u", int'(r_u), 0);
        seen = 0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
            if (ov_u | ov_s | ov_m) seen++;
        end
        chk("midrst_no_result", seen, 0);
        run_op("after_rst", v93);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
